// File: rtl/bsg_relay_piso_pkg.sv
// Shared helpers for the bsg_relay_piso width-narrowing stage.
// They derive the chunk count and check that a width pairing is legal.
package bsg_relay_piso_pkg;

    // Returns the number of output chunks that make up one input word.
    function automatic int piso_els(input int win, input int wout);
        return win / wout;
    endfunction

    // Checks that a width pairing splits evenly into at least two chunks.
    function automatic bit piso_cfg_ok(input int win, input int wout);
        return (wout > 0) && ((win % wout) == 0) && ((win / wout) >= 2);
    endfunction

endpackage

// File: rtl/bsg_relay_piso_hold.sv
// One-entry word buffer for bsg_relay_piso.
// It parks a word that arrives while the shifter is still busy with
// the previous word. Because of this buffer, the upstream ready signal
// can come straight from a flop.
module bsg_relay_piso_hold #(
    parameter int width_p = 32
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_capture,
    input  logic               i_release,
    input  logic [width_p-1:0] i_data,
    output logic [width_p-1:0] o_data,
    output logic               o_v
);

    logic [width_p-1:0] r_hold;
    logic               r_hold_v;

    // A capture fills the buffer. A release empties it once the shifter
    // has taken the word. The two never coincide: capture needs the
    // buffer empty, and release needs it full.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hold   <= '0;
            r_hold_v <= 1'b0;
        end else if (i_capture) begin
            r_hold   <= i_data;
            r_hold_v <= 1'b1;
        end else if (i_release) begin
            r_hold_v <= 1'b0;
        end
    end

    assign o_data = r_hold;
    assign o_v    = r_hold_v;

endmodule

// File: rtl/bsg_relay_piso.sv
// bsg_relay_piso: parallel-in/serial-out stage placed after a relay FIFO.
// Each input word leaves as width_in_p/width_out_p chunks, least
// significant chunk first. A one-word holding buffer keeps ready_o
// registered and allows one chunk per cycle.
// Optional macro BSG_RELAY_PISO_LAST_EN adds the last_o port. last_o
// marks the final chunk of each word.
module bsg_relay_piso
    import bsg_relay_piso_pkg::*;
#(
    parameter int width_in_p  = 32,
    parameter int width_out_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    input  logic [width_in_p-1:0]  data_i,
    output logic                   ready_o,
    output logic                   v_o,
    output logic [width_out_p-1:0] data_o,
    input  logic                   ready_i
`ifdef BSG_RELAY_PISO_LAST_EN
   ,output logic                   last_o
`endif
);

    localparam int els_lp   = piso_els(width_in_p, width_out_p);
    localparam int cnt_w_lp = (els_lp > 1) ? $clog2(els_lp) : 1;
    localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(els_lp - 1);

    if (!piso_cfg_ok(width_in_p, width_out_p)) begin : g_cfg_bad
        $error("bsg_relay_piso: width_in_p must be a multiple of width_out_p with at least two chunks");
    end

    logic [width_in_p-1:0] r_shift;
    logic                  r_shift_v;
    logic [cnt_w_lp-1:0]   r_cnt;

    logic [width_in_p-1:0] w_hold_data;
    logic                  w_hold_v;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_last_chunk;
    logic                  w_done;
    logic                  w_load;
    logic                  w_capture;
    logic                  w_release;

    assign w_in_fire    = v_i & ~w_hold_v;
    assign w_out_fire   = r_shift_v & ready_i;
    assign w_last_chunk = (r_cnt == cnt_last_lp);
    assign w_done       = w_out_fire & w_last_chunk;
    assign w_load       = ~r_shift_v | w_done;
    assign w_capture    = w_in_fire & r_shift_v & ~w_done;
    assign w_release    = w_load & w_hold_v;

    bsg_relay_piso_hold #(
        .width_p (width_in_p)
    ) u_hold (
        .i_clk     (clk_i),
        .i_reset_n (reset_n_i),
        .i_capture (w_capture),
        .i_release (w_release),
        .i_data    (data_i),
        .o_data    (w_hold_data),
        .o_v       (w_hold_v)
    );

    // When the shifter is empty or finishing its last chunk, it reloads.
    // A parked word takes priority over a new input word. Otherwise each
    // accepted chunk shifts the next chunk down into the output slot.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_shift   <= '0;
            r_shift_v <= 1'b0;
            r_cnt     <= '0;
        end else if (w_load) begin
            if (w_hold_v) begin
                r_shift   <= w_hold_data;
                r_shift_v <= 1'b1;
                r_cnt     <= '0;
            end else if (w_in_fire) begin
                r_shift   <= data_i;
                r_shift_v <= 1'b1;
                r_cnt     <= '0;
            end else begin
                r_shift_v <= 1'b0;
            end
        end else if (w_out_fire) begin
            r_shift <= r_shift >> width_out_p;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign ready_o = ~w_hold_v;
    assign v_o     = r_shift_v;
    assign data_o  = r_shift[width_out_p-1:0];

`ifdef BSG_RELAY_PISO_LAST_EN
    assign last_o  = r_shift_v & w_last_chunk;
`endif

endmodule

// File: tb/tb_bsg_relay_piso.sv
// Self-checking bench for bsg_relay_piso with 32-bit words split into 8-bit chunks.
// The directed vector table walks through these cases:
//   - single-word serialisation
//   - back-to-back words
//   - a new word arriving in the same cycle as the done chunk
//   - downstream stalls
// Hand-written sequences cover:
//   - reset asserted mid-word
//   - a long random run checked against a chunk scoreboard
module tb_bsg_relay_piso;

    localparam int WIN  = 32;
    localparam int WOUT = 8;
    localparam int ELS  = WIN / WOUT;

    logic        clk = 1'b0;
    logic        rstN;
    logic        vIn;
    logic [31:0] dataIn;
    logic        readyOut;
    logic        vOut;
    logic [7:0]  dataOut;
    logic        readyIn;
    logic        lastOut;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        vI;
        logic [31:0] dI;
        logic        rdyI;
        logic        expV;
        logic [7:0]  expD;
        logic        expRdy;
        logic        expLast;
    } vec_t;

    vec_t vecs[$];

    // Free-running 100 MHz-style clock.
    always #5 clk = ~clk;

    bsg_relay_piso #(
        .width_in_p  (WIN),
        .width_out_p (WOUT)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (rstN),
        .v_i       (vIn),
        .data_i    (dataIn),
        .ready_o   (readyOut),
        .v_o       (vOut),
        .data_o    (dataOut),
        .ready_i   (readyIn)
`ifdef BSG_RELAY_PISO_LAST_EN
       ,.last_o    (lastOut)
`endif
    );

`ifndef BSG_RELAY_PISO_LAST_EN
    assign lastOut = 1'b0;
`endif

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r);
        vIn     = v;
        dataIn  = d;
        readyIn = r;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    task automatic addVec(input logic vI, input logic [31:0] dI, input logic rdyI,
                          input logic expV, input logic [7:0] expD, input logic expRdy,
                          input logic expLast);
        vec_t v;
        v.vI = vI; v.dI = dI; v.rdyI = rdyI;
        v.expV = expV; v.expD = expD; v.expRdy = expRdy; v.expLast = expLast;
        vecs.push_back(v);
    endtask

    initial begin
        logic [8:0]  sb[$];
        logic [8:0]  expChunk;
        logic [31:0] word;
        logic        pending;
        int          sent;
        int          cycles;

        // Row columns: v_i, data_i, ready_i | expected v_o, data_o, ready_o, last_o.
        // Each row gives the outputs seen during its cycle, before the clock edge.

        // Single word.
        addVec(0, 32'h0,        1, 0, 8'h00, 1, 0);
        addVec(1, 32'hDDCCBBAA, 1, 0, 8'h00, 1, 0);
        addVec(0, 32'h0,        1, 1, 8'hAA, 1, 0);
        addVec(0, 32'h0,        1, 1, 8'hBB, 1, 0);
        addVec(0, 32'h0,        1, 1, 8'hCC, 1, 0);
        addVec(0, 32'h0,        1, 1, 8'hDD, 1, 1);

        // Three back-to-back words.
        addVec(1, 32'h03020100, 1, 0, 8'hDD, 1, 0);
        addVec(1, 32'h07060504, 1, 1, 8'h00, 1, 0);
        addVec(1, 32'h0B0A0908, 1, 1, 8'h01, 0, 0);
        addVec(1, 32'h0B0A0908, 1, 1, 8'h02, 0, 0);
        addVec(1, 32'h0B0A0908, 1, 1, 8'h03, 0, 1);
        addVec(1, 32'h0B0A0908, 1, 1, 8'h04, 1, 0);
        addVec(0, 32'h0,        1, 1, 8'h05, 0, 0);
        addVec(0, 32'h0,        1, 1, 8'h06, 0, 0);
        addVec(0, 32'h0,        1, 1, 8'h07, 0, 1);
        addVec(0, 32'h0,        1, 1, 8'h08, 1, 0);
        addVec(0, 32'h0,        1, 1, 8'h09, 1, 0);
        addVec(0, 32'h0,        1, 1, 8'h0A, 1, 0);
        addVec(0, 32'h0,        1, 1, 8'h0B, 1, 1);

        // New word arrives in the same cycle as the done chunk.
        addVec(1, 32'h44332211, 1, 0, 8'h0B, 1, 0);
        addVec(0, 32'h0,        1, 1, 8'h11, 1, 0);
        addVec(0, 32'h0,        1, 1, 8'h22, 1, 0);
        addVec(0, 32'h0,        1, 1, 8'h33, 1, 0);
        addVec(1, 32'h88776655, 1, 1, 8'h44, 1, 1);
        addVec(0, 32'h0,        1, 1, 8'h55, 1, 0);
        addVec(0, 32'h0,        1, 1, 8'h66, 1, 0);
        addVec(0, 32'h0,        1, 1, 8'h77, 1, 0);
        addVec(0, 32'h0,        1, 1, 8'h88, 1, 1);

        // Downstream stall: the second word is held and the output stays stable.
        addVec(1, 32'h03020100, 0, 0, 8'h88, 1, 0);
        addVec(1, 32'h07060504, 0, 1, 8'h00, 1, 0);
        addVec(0, 32'h0,        0, 1, 8'h00, 0, 0);
        addVec(0, 32'h0,        0, 1, 8'h00, 0, 0);
        addVec(0, 32'h0,        1, 1, 8'h00, 0, 0);
        addVec(0, 32'h0,        0, 1, 8'h01, 0, 0);
        addVec(0, 32'h0,        1, 1, 8'h01, 0, 0);
        addVec(0, 32'h0,        1, 1, 8'h02, 0, 0);
        addVec(0, 32'h0,        1, 1, 8'h03, 0, 1);
        addVec(0, 32'h0,        1, 1, 8'h04, 1, 0);
        addVec(0, 32'h0,        1, 1, 8'h05, 1, 0);
        addVec(0, 32'h0,        1, 1, 8'h06, 1, 0);
        addVec(0, 32'h0,        1, 1, 8'h07, 1, 1);
        addVec(0, 32'h0,        1, 0, 8'h07, 1, 0);

        // Reset state.
        applyStimulus(0, 32'h0, 0);
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_v_o",     32'(vOut),     32'h0);
        checkOutput("reset_ready_o", 32'(readyOut), 32'h1);
        checkOutput("reset_data_o",  32'(dataOut),  32'h0);
`ifdef BSG_RELAY_PISO_LAST_EN
        checkOutput("reset_last_o",  32'(lastOut),  32'h0);
`endif
        @(posedge clk); #1;
        rstN = 1'b1;

        // Directed vector table.
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].vI, vecs[i].dI, vecs[i].rdyI);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_v_o", i),     32'(vOut),     32'(vecs[i].expV));
            checkOutput($sformatf("vec%0d_data_o", i),  32'(dataOut),  32'(vecs[i].expD));
            checkOutput($sformatf("vec%0d_ready_o", i), 32'(readyOut), 32'(vecs[i].expRdy));
`ifdef BSG_RELAY_PISO_LAST_EN
            checkOutput($sformatf("vec%0d_last_o", i),  32'(lastOut),  32'(vecs[i].expLast));
`endif
            @(posedge clk); #1;
        end

        // Reset mid-word: the partial word and the held word are dropped immediately.
        applyStimulus(1, 32'hCAFEF00D, 0);
        @(posedge clk); #1;
        applyStimulus(1, 32'h12345678, 0);
        @(posedge clk); #1;
        applyStimulus(0, 32'h0, 0);
        checkOutput("midword_pre_v_o",     32'(vOut),     32'h1);
        checkOutput("midword_pre_data_o",  32'(dataOut),  32'h0D);
        checkOutput("midword_pre_ready_o", 32'(readyOut), 32'h0);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("midword_rst_v_o",     32'(vOut),     32'h0);
        checkOutput("midword_rst_ready_o", 32'(readyOut), 32'h1);
        checkOutput("midword_rst_data_o",  32'(dataOut),  32'h0);
        @(posedge clk); #1;
        rstN = 1'b1;
        applyStimulus(0, 32'h0, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("post_reset_idle%0d_v_o", i), 32'(vOut), 32'h0);
            @(posedge clk); #1;
        end

        // Random run: random valid and ready, 1000 words, checked against a chunk scoreboard.
        sent    = 0;
        cycles  = 0;
        pending = 1'b0;
        word    = 32'h0;
        while ((sent < 1000 || sb.size() != 0) && cycles < 20000) begin
            if (!pending && sent < 1000 && $urandom_range(0, 3) != 0) begin
                word    = $urandom;
                pending = 1'b1;
            end
            applyStimulus(pending, pending ? word : 32'h0, $urandom_range(0, 1) == 1);
            @(negedge clk);
            if (vOut && readyIn) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL rand_extra_chunk actual=%h expected=none", dataOut);
                end else begin
                    expChunk = sb.pop_front();
                    checkOutput("rand_data_o", 32'(dataOut), 32'(expChunk[7:0]));
`ifdef BSG_RELAY_PISO_LAST_EN
                    checkOutput("rand_last_o", 32'(lastOut), 32'(expChunk[8]));
`endif
                end
            end
            if (vIn && readyOut) begin
                for (int k = 0; k < ELS; k++) begin
                    sb.push_back({(k == ELS - 1), word[k*WOUT +: WOUT]});
                end
                sent++;
                pending = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("rand_no_timeout", 32'(cycles < 20000), 32'h1);
        checkOutput("rand_words_sent", 32'(sent),           32'd1000);
        checkOutput("rand_sb_drained", 32'(sb.size()),      32'h0);

        applyStimulus(0, 32'h0, 1);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("final_idle_v_o",     32'(vOut),     32'h0);
        checkOutput("final_idle_ready_o", 32'(readyOut), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
